pll_lock_rst_seq: RTL and testbench

- Reset sequencer that sits directly downstream of the USB PLL (480 MHz / 60 MHz outputs) and consumes its lock output.
- Clocked from the free-running 24 MHz board oscillator, which is the same clock that feeds the PLL input, so the block keeps running while the PLL is unlocked.
- Drives the PLL RESET pin, waits for a lock that is stable, then releases the USB PHY reset and, after a further delay, the core reset.
- On lock loss it re-asserts both resets, counts the event, and re-pulses the PLL if lock does not return within a timeout.

---
 rtl/pll_lock_rst_seq_if.sv | 37 +++
 rtl/pll_lock_rst_seq.sv | 158 +++++++++++++++
 tb/tb_pll_lock_rst_seq.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/pll_lock_rst_seq_if.sv
// rtl/pll_lock_rst_seq_if.sv - lock input, restart request and reset outputs of the PLL reset sequencer
interface pll_lock_rst_seq_if #(
    parameter int CNT_W = 8
);
    logic             lock_in;
    logic             soft_rst_req;
    logic             pll_rst;
    logic             phy_rst_n;
    logic             core_rst_n;
    logic             ready;
    logic             timeout_err;
    logic [CNT_W-1:0] relock_cnt;

    // sequencer side: consumes lock and restart, drives the resets and status
    modport master (
        input  lock_in,
        input  soft_rst_req,
        output pll_rst,
        output phy_rst_n,
        output core_rst_n,
        output ready,
        output timeout_err,
        output relock_cnt
    );

    // environment side: PLL and system controller
    modport slave (
        output lock_in,
        output soft_rst_req,
        input  pll_rst,
        input  phy_rst_n,
        input  core_rst_n,
        input  ready,
        input  timeout_err,
        input  relock_cnt
    );
endinterface

// File: rtl/pll_lock_rst_seq.sv
// rtl/pll_lock_rst_seq.sv - PLL reset pulse, stable-lock wait and staged PHY/core reset release
module pll_lock_rst_seq #(
    parameter int SYNC_STAGES    = 2,
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 24000,
    parameter int LOCK_STABLE    = 2400,
    parameter int PHY_TO_CORE    = 64,
    parameter int CNT_W          = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    pll_lock_rst_seq_if.master      bus
);

    localparam int MAX_AB = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CD = (LOCK_STABLE > PHY_TO_CORE) ? LOCK_STABLE : PHY_TO_CORE;
    localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW     = $clog2(MAX_P + 1);

    localparam logic [CW-1:0] C_PLL = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] C_TO  = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] C_STB = CW'(LOCK_STABLE - 1);
    localparam logic [CW-1:0] C_P2C = CW'(PHY_TO_CORE - 1);

    typedef enum logic [2:0] {
        S_PLLRST = 3'd0,
        S_WAIT   = 3'd1,
        S_STABLE = 3'd2,
        S_PHY    = 3'd3,
        S_RUN    = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [CW-1:0]          r_cnt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_lock_s;
    logic                   w_timeout;
    logic                   w_loss;
    logic                   w_restart;

    logic                   w_pll_rst;
    logic                   w_phy_rst_n;
    logic                   w_core_rst_n;

    logic                   r_pll_rst;
    logic                   r_phy_rst_n;
    logic                   r_core_rst_n;
    logic                   r_ready;
    logic                   r_timeout_err;
    logic [CNT_W-1:0]       r_relock_cnt;

    assign w_lock_s = r_sync[SYNC_STAGES-1];

    // bring the asynchronous PLL lock into the oscillator domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.lock_in};
        end
    end

    // state register and shared phase counter; counter restarts on every transition
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_PLLRST;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_restart) begin
                r_cnt <= '0;
            end else if (r_state != S_RUN) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    // next-state decode; a restart request overrides every other transition
    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        w_loss    = 1'b0;
        case (r_state)
            S_PLLRST: begin
                if (r_cnt == C_PLL) w_next = S_WAIT;
            end
            S_WAIT: begin
                if (w_lock_s) begin
                    w_next = S_STABLE;
                end else if (r_cnt == C_TO) begin
                    w_timeout = 1'b1;
                    w_next    = S_PLLRST;
                end
            end
            S_STABLE: begin
                if (!w_lock_s) begin
                    w_next = S_WAIT;
                end else if (r_cnt == C_STB) begin
                    w_next = S_PHY;
                end
            end
            S_PHY: begin
                if (!w_lock_s) begin
                    w_loss = 1'b1;
                    w_next = S_WAIT;
                end else if (r_cnt == C_P2C) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                if (!w_lock_s) begin
                    w_loss = 1'b1;
                    w_next = S_WAIT;
                end
            end
            default: w_next = S_PLLRST;
        endcase
        if (bus.soft_rst_req) w_next = S_PLLRST;
        w_restart = bus.soft_rst_req || (w_next != r_state);
    end

    // reset levels follow the state being entered so they change on the transition edge
    always_comb begin
        w_pll_rst    = (w_next == S_PLLRST);
        w_phy_rst_n  = (w_next == S_PHY) || (w_next == S_RUN);
        w_core_rst_n = (w_next == S_RUN);
    end

    // registered outputs plus sticky timeout flag and saturating lock-loss count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pll_rst     <= 1'b1;
            r_phy_rst_n   <= 1'b0;
            r_core_rst_n  <= 1'b0;
            r_ready       <= 1'b0;
            r_timeout_err <= 1'b0;
            r_relock_cnt  <= '0;
        end else begin
            r_pll_rst    <= w_pll_rst;
            r_phy_rst_n  <= w_phy_rst_n;
            r_core_rst_n <= w_core_rst_n;
            r_ready      <= w_core_rst_n;
            if (w_timeout) r_timeout_err <= 1'b1;
            if (w_loss && !bus.soft_rst_req && (r_relock_cnt != {CNT_W{1'b1}})) begin
                r_relock_cnt <= r_relock_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.pll_rst     = r_pll_rst;
    assign bus.phy_rst_n   = r_phy_rst_n;
    assign bus.core_rst_n  = r_core_rst_n;
    assign bus.ready       = r_ready;
    assign bus.timeout_err = r_timeout_err;
    assign bus.relock_cnt  = r_relock_cnt;

endmodule

// File: tb/tb_pll_lock_rst_seq.sv
// tb/tb_pll_lock_rst_seq.sv - scoreboard bench for the PLL lock reset sequencer
module tb_pll_lock_rst_seq;

    logic clk;
    logic rst_n;
    int   ecnt;
    int   n_cmp;
    int   n_bad;

    pll_lock_rst_seq_if #(.CNT_W(2)) bus ();

    pll_lock_rst_seq #(
        .SYNC_STAGES   (2),
        .PLL_RST_CYCLES(4),
        .LOCK_TIMEOUT  (20),
        .LOCK_STABLE   (10),
        .PHY_TO_CORE   (5),
        .CNT_W         (2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        int         cyc;
        logic [6:0] v;
        string      name;
    } exp_t;

    exp_t sb[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // edges counted from reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ecnt <= 0;
        else        ecnt <= ecnt + 1;
    end

    function automatic logic [6:0] actual();
        return {bus.pll_rst, bus.phy_rst_n, bus.core_rst_n, bus.ready,
                bus.timeout_err, bus.relock_cnt};
    endfunction

    task automatic chk(input string name, input logic [6:0] want);
        logic [6:0] got;
        got = actual();
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s @edge %0d: got pll/phy/core/rdy/terr/rc=%b want %b", name, ecnt, got, want);
        end
    endtask

    function automatic void expect_at(input int c, input logic [6:0] v, input string n);
        exp_t e;
        e.cyc  = c;
        e.v    = v;
        e.name = n;
        sb.push_back(e);
    endfunction

    // monitor: pops due expectations and checks the reset ordering invariant
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.core_rst_n === 1'b1) begin
                n_cmp++;
                if (!(bus.phy_rst_n === 1'b1 && bus.pll_rst === 1'b0)) begin
                    n_bad++;
                    $display("FAIL invariant @edge %0d: core released with phy_rst_n=%b pll_rst=%b",
                             ecnt, bus.phy_rst_n, bus.pll_rst);
                end
            end
            while (sb.size() > 0 && sb[0].cyc <= ecnt) begin
                exp_t e;
                e = sb.pop_front();
                if (e.cyc < ecnt) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL %s: check for edge %0d missed, now edge %0d", e.name, e.cyc, ecnt);
                end else begin
                    chk(e.name, e.v);
                end
            end
        end
    end

    task automatic wait_edge(input int n);
        while (ecnt < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        bus.lock_in = 1'b1;
        bus.soft_rst_req = 1'b0;

        // clean bring-up
        expect_at(0,  7'b1_0_0_0_0_00, "reset_state");
        expect_at(3,  7'b1_0_0_0_0_00, "pllrst_held");
        expect_at(4,  7'b0_0_0_0_0_00, "pllrst_release");
        expect_at(14, 7'b0_0_0_0_0_00, "phy_not_yet");
        expect_at(15, 7'b0_1_0_0_0_00, "phy_release");
        expect_at(19, 7'b0_1_0_0_0_00, "core_not_yet");
        expect_at(20, 7'b0_1_1_1_0_00, "core_release");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // lock loss in RUN, then relock
        expect_at(27, 7'b0_1_1_1_0_00, "loss_latency_hold");
        expect_at(28, 7'b0_0_0_0_0_01, "loss_resets");
        expect_at(40, 7'b0_0_0_0_0_01, "relock_phy_wait");
        expect_at(41, 7'b0_1_0_0_0_01, "relock_phy");
        expect_at(45, 7'b0_1_0_0_0_01, "relock_core_wait");
        expect_at(46, 7'b0_1_1_1_0_01, "relock_core");
        wait_edge(25);
        bus.lock_in = 1'b0;
        wait_edge(28);
        bus.lock_in = 1'b1;

        // three more losses saturate the count
        for (int k = 0; k < 3; k++) begin
            int e0;
            logic [1:0] rc;
            e0 = 50 + 25 * k;
            rc = (k == 0) ? 2'd2 : 2'd3;
            expect_at(e0 + 3,  {5'b0_0_0_0_0, rc}, "sat_loss");
            expect_at(e0 + 21, {5'b0_1_1_1_0, rc}, "sat_run");
            wait_edge(e0);
            bus.lock_in = 1'b0;
            wait_edge(e0 + 3);
            bus.lock_in = 1'b1;
        end

        // soft reset from RUN
        expect_at(125, 7'b0_1_1_1_0_11, "soft_before");
        expect_at(126, 7'b1_0_0_0_0_11, "soft_resets");
        expect_at(129, 7'b1_0_0_0_0_11, "soft_pll_held");
        expect_at(130, 7'b0_0_0_0_0_11, "soft_pll_release");
        expect_at(141, 7'b0_1_0_0_0_11, "soft_phy");
        expect_at(146, 7'b0_1_1_1_0_11, "soft_core");
        wait_edge(125);
        bus.soft_rst_req = 1'b1;
        wait_edge(126);
        bus.soft_rst_req = 1'b0;

        // one-cycle lock glitch in STABLE restarts the debounce
        expect_at(151, 7'b1_0_0_0_0_11, "glitch_soft");
        expect_at(171, 7'b0_0_0_0_0_11, "glitch_phy_wait");
        expect_at(172, 7'b0_1_0_0_0_11, "glitch_phy");
        expect_at(177, 7'b0_1_1_1_0_11, "glitch_core");
        wait_edge(150);
        bus.soft_rst_req = 1'b1;
        wait_edge(151);
        bus.soft_rst_req = 1'b0;
        wait_edge(158);
        bus.lock_in = 1'b0;
        wait_edge(159);
        bus.lock_in = 1'b1;

        // lock absent: timeout and periodic PLL re-pulse
        expect_at(181, 7'b1_0_0_0_0_11, "to_soft");
        expect_at(185, 7'b0_0_0_0_0_11, "to_wait");
        expect_at(204, 7'b0_0_0_0_0_11, "to_not_yet");
        expect_at(205, 7'b1_0_0_0_1_11, "to_fire");
        expect_at(209, 7'b0_0_0_0_1_11, "to_pulse_end");
        expect_at(228, 7'b0_0_0_0_1_11, "to2_not_yet");
        expect_at(229, 7'b1_0_0_0_1_11, "to2_fire");
        wait_edge(180);
        bus.soft_rst_req = 1'b1;
        bus.lock_in = 1'b0;
        wait_edge(181);
        bus.soft_rst_req = 1'b0;
        wait_edge(229);
        bus.lock_in = 1'b1;

        // asynchronous reset while in PHY
        expect_at(244, 7'b0_1_0_0_1_11, "phy_before_rst");
        expect_at(245, 7'b0_1_0_0_1_11, "phy_hold");
        wait_edge(246);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_reset", 7'b1_0_0_0_0_00);
        @(negedge clk);
        expect_at(4,  7'b0_0_0_0_0_00, "post_rst_pll");
        expect_at(20, 7'b0_1_1_1_0_00, "post_rst_core");
        rst_n = 1'b1;
        wait_edge(22);

        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
